speed_encoder: RTL and testbench
================================

SPEED_ENCODER -- requirements
Module: speed_encoder

Interface
REQ-001 SHALL have parameter DB_CNT, default 20: number of consecutive stable CLK cycles required to accept a new debounced input vector (range 2..65535).
REQ-002 SHALL have parameter RESET_ID, default 3'd0: SUBSAMPLE_ID value loaded on reset.
REQ-003 SHALL have port CLK  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous active-high reset.
REQ-005 SHALL have port SEL_IN  input  8  asynchronous speed-select switches, one-hot intended, bit n selects ID n.
REQ-006 SHALL have port BTN_UP  input  1  asynchronous pushbutton, step ID up.
REQ-007 SHALL have port BTN_DN  input  1  asynchronous pushbutton, step ID down.
REQ-008 SHALL have port SUBSAMPLE_ID  output  3  registered encoded speed index, feeds the one-hot speed decoder.
REQ-009 SHALL have port ID_CHANGED  output  1  one-cycle pulse in the cycle SUBSAMPLE_ID takes a new value.
REQ-010 SHALL have port SAMPLE_EN  output  1  registered sample strobe, one cycle high every 2^SUBSAMPLE_ID cycles.
REQ-011 SHALL have port ERR  output  1  registered flag, high while debounced SEL_IN has more than one bit set.

Function
REQ-012 SHALL synchronise SEL_IN, BTN_UP, BTN_DN through two flops each before any other use.
REQ-013 SHALL debounce the 10-bit synchronised vector with one shared counter: any bit change clears the counter; the debounced register loads the vector when the counter reaches DB_CNT-1 with no change.
REQ-014 SHALL update SUBSAMPLE_ID between DB_CNT+2 and DB_CNT+4 CLK cycles after the inputs settle; the count is fixed for a given implementation and documented in the RTL header.
REQ-015 SHALL load SUBSAMPLE_ID with index n when debounced SEL_IN changes to a value with exactly bit n set.
REQ-016 SHALL keep SUBSAMPLE_ID unchanged when debounced SEL_IN is all-zero or multi-hot; multi-hot sets ERR=1, which clears when the vector becomes zero or one-hot.
REQ-017 SHALL increment SUBSAMPLE_ID on a debounced BTN_UP rising edge, saturating at 7 (no wrap).
REQ-018 SHALL decrement SUBSAMPLE_ID on a debounced BTN_DN rising edge, saturating at 0 (no wrap).
REQ-019 SHALL ignore both button edges when they occur in the same cycle.
REQ-020 SHALL give a valid one-hot switch load priority over a button edge occurring in the same cycle.
REQ-021 SHALL NOT pulse ID_CHANGED when a load or step produces the current value (e.g. saturation).
REQ-022 SHALL drive SAMPLE_EN from a 7-bit divider counting 0..2^ID-1; SAMPLE_EN=1 in the cycle after the counter is 0; ID=0 gives SAMPLE_EN constantly high.
REQ-023 SHALL clear the divider in the ID_CHANGED cycle, so the first SAMPLE_EN at the new rate occurs in the next cycle.

Reset
REQ-024 SHALL, while RESET=1, force SUBSAMPLE_ID=RESET_ID, ID_CHANGED=0, SAMPLE_EN=0, ERR=0, and clear sync flops, debounce counter, debounced register and divider to zero.
REQ-025 SHALL treat a switch held one-hot through reset as a change from zero after release, loading its index after debounce.
REQ-026 SHALL abandon any debounce in progress on reset mid-operation, with no partial update.

Configuration
REQ-027 SHALL, with macro SPEED_ENCODER_BUTTONS_EN defined, implement BTN_UP/BTN_DN stepping per REQ-017..REQ-020.
REQ-028 SHALL, without SPEED_ENCODER_BUTTONS_EN, keep the BTN_UP/BTN_DN ports but ignore them, and exclude their sync/debounce logic; SUBSAMPLE_ID changes only via SEL_IN.

Verification
REQ-029 SHALL cover: reset, SEL_IN=8'h10 held for DB_CNT+5 cycles -> SUBSAMPLE_ID=4, one ID_CHANGED pulse, SAMPLE_EN every 16 cycles.
REQ-030 SHALL cover: SEL_IN glitching 8'h01<->8'h02 every DB_CNT/2 cycles -> no ID change and no ID_CHANGED.
REQ-031 SHALL cover: SEL_IN=8'h05 stable -> ERR=1 and ID held; then 8'h04 -> ERR=0, ID=2.
REQ-032 SHALL cover (buttons enabled): ID=7, BTN_UP pressed -> ID stays 7, no ID_CHANGED; BTN_DN pressed 8 times -> ID steps 6..0, then 0 stays 0.
REQ-033 SHALL cover: BTN_UP and BTN_DN edges in the same cycle -> no change; switch load to 8'h08 with a simultaneous BTN_UP edge -> ID=3.
REQ-034 SHALL cover: RESET asserted mid-debounce and mid-divider -> all outputs 0, ID=RESET_ID asynchronously; SAMPLE_EN restarts at 2^RESET_ID spacing.

Source files
------------

// File: rtl/speed_encoder.sv
// Speed-select encoder: synchronised, debounced switches/buttons -> SUBSAMPLE_ID plus a 2^ID sample strobe.
// SUBSAMPLE_ID updates DB_CNT+3 cycles after inputs settle; define SPEED_ENCODER_BUTTONS_EN to enable BTN_UP/BTN_DN stepping.
module speed_encoder #(
   parameter int unsigned DB_CNT   = 20,
   parameter logic [2:0]  RESET_ID = 3'd0
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] SEL_IN,
   input  logic       BTN_UP,
   input  logic       BTN_DN,
   output logic [2:0] SUBSAMPLE_ID,
   output logic       ID_CHANGED,
   output logic       SAMPLE_EN,
   output logic       ERR
);

`ifdef SPEED_ENCODER_BUTTONS_EN
   localparam int VW = 10;
   logic [VW-1:0] raw_vec;
   assign raw_vec = {BTN_DN, BTN_UP, SEL_IN};
`else
   localparam int VW = 8;
   logic [VW-1:0] raw_vec;
   logic          unused_btn;
   assign raw_vec    = SEL_IN;
   assign unused_btn = BTN_UP ^ BTN_DN;
`endif

   logic [VW-1:0] sync1, sync2, samp, deb;
   logic [15:0]   db_cnt;
   logic          accept;

   // samp is the previous synchronised vector; any difference restarts the stability count
   assign accept = (sync2 == samp) && (db_cnt == 16'(DB_CNT - 1));

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1  <= '0;
         sync2  <= '0;
         samp   <= '0;
         deb    <= '0;
         db_cnt <= '0;
      end else begin
         sync1 <= raw_vec;
         sync2 <= sync1;
         samp  <= sync2;
         if (sync2 != samp)
            db_cnt <= '0;
         else if (!accept)
            db_cnt <= db_cnt + 16'd1;
         if (accept)
            deb <= samp;
      end
   end

   logic [7:0] new_sel;
   logic [2:0] sel_idx;
   logic       sel_one_hot, sel_multi, sel_load;
   logic [2:0] next_id;
   logic       id_change;

   assign new_sel     = samp[7:0];
   assign sel_one_hot = (new_sel != 8'd0) && ((new_sel & (new_sel - 8'd1)) == 8'd0);
   assign sel_multi   = (new_sel != 8'd0) && !sel_one_hot;
   assign sel_load    = accept && (new_sel != deb[7:0]) && sel_one_hot;

`ifdef SPEED_ENCODER_BUTTONS_EN
   logic up_edge, dn_edge;
   assign up_edge = accept && samp[8] && !deb[8];
   assign dn_edge = accept && samp[9] && !deb[9];
`endif

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sel_idx = 3'd0;
      for (int i = 0; i < 8; i++)
         if (new_sel[i]) sel_idx = 3'(i);
   end

   always_comb begin
      next_id = SUBSAMPLE_ID;
      if (sel_load)
         next_id = sel_idx;
`ifdef SPEED_ENCODER_BUTTONS_EN
      else if (up_edge && !dn_edge && SUBSAMPLE_ID != 3'd7)
         next_id = SUBSAMPLE_ID + 3'd1;
      else if (dn_edge && !up_edge && SUBSAMPLE_ID != 3'd0)
         next_id = SUBSAMPLE_ID - 3'd1;
`endif
   end

   assign id_change = (next_id != SUBSAMPLE_ID);

   logic [6:0] div, div_max;
   assign div_max = 7'((8'd1 << SUBSAMPLE_ID) - 8'd1);

   // Divider restarts with the ID update so the new rate begins with a strobe the following cycle
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         SUBSAMPLE_ID <= RESET_ID;
         ID_CHANGED   <= 1'b0;
         ERR          <= 1'b0;
         SAMPLE_EN    <= 1'b0;
         div          <= '0;
      end else begin
         SUBSAMPLE_ID <= next_id;
         ID_CHANGED   <= id_change;
         if (accept)
            ERR <= sel_multi;
         SAMPLE_EN <= (div == 7'd0);
         if (id_change || div == div_max)
            div <= '0;
         else
            div <= div + 7'd1;
      end
   end

endmodule

// File: tb/tb_speed_encoder.sv
// Scoreboard bench for speed_encoder: segment-level reference model predicts ID updates, ERR and strobe spacing.
module tb_speed_encoder;

   localparam int         DB  = 8;
   localparam logic [2:0] RID = 3'd2;
   localparam int         LONG = DB + 5;
`ifdef SPEED_ENCODER_BUTTONS_EN
   localparam logic [9:0] KEY_MASK = 10'h3FF;
`else
   localparam logic [9:0] KEY_MASK = 10'h0FF;
`endif

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] SEL_IN;
   logic       BTN_UP, BTN_DN;
   logic [2:0] SUBSAMPLE_ID;
   logic       ID_CHANGED, SAMPLE_EN, ERR;

   speed_encoder #(.DB_CNT(DB), .RESET_ID(RID)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .SEL_IN       (SEL_IN),
      .BTN_UP       (BTN_UP),
      .BTN_DN       (BTN_DN),
      .SUBSAMPLE_ID (SUBSAMPLE_ID),
      .ID_CHANGED   (ID_CHANGED),
      .SAMPLE_EN    (SAMPLE_EN),
      .ERR          (ERR)
   );

   always #5 CLK = ~CLK;

   int unsigned cyc = 0;
   always @(posedge CLK) cyc++;

   typedef struct {
      logic [2:0]  id;
      int unsigned start;
   } exp_t;

   exp_t       sb_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [2:0] m_id;
   logic [9:0] m_deb;
   logic [9:0] last_vec;

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act >= lo && act <= hi)
         n_pass++;
      else
         $display("FAIL %s: got %0d, wanted %0d..%0d (t=%0t)", name, act, lo, hi, $time);
   endtask

   task automatic check(input string name, input int act, input int exp);
      check_range(name, act, exp, exp);
   endtask

   function automatic int exp_err();
      return ($countones(m_deb[7:0]) > 1) ? 1 : 0;
   endfunction

   // Reference model: a vector held stably is accepted as a whole and applied to the ID rules
   task automatic model_accept(input logic [9:0] v, input int unsigned start);
      logic [7:0] s;
      logic [2:0] nid;
      s   = v[7:0];
      nid = m_id;
      if (s != m_deb[7:0] && $countones(s) == 1)
         nid = 3'($clog2(s));
`ifdef SPEED_ENCODER_BUTTONS_EN
      else begin
         bit up, dn;
         up = v[8] && !m_deb[8];
         dn = v[9] && !m_deb[9];
         if (up && !dn)
            nid = (m_id == 3'd7) ? 3'd7 : m_id + 3'd1;
         else if (dn && !up)
            nid = (m_id == 3'd0) ? 3'd0 : m_id - 3'd1;
      end
`endif
      if (nid != m_id)
         sb_q.push_back('{id: nid, start: start});
      m_id  = nid;
      m_deb = v;
   endtask

   task automatic drive(input logic [9:0] v);
      SEL_IN   = v[7:0];
      BTN_UP   = v[8];
      BTN_DN   = v[9];
      last_vec = v;
   endtask

   // Lengths below DB are never accepted; LONG and above always are
   task automatic settle(input logic [9:0] v, input int len);
      int unsigned start;
      start = cyc;
      if (len >= LONG)
         model_accept(v, start);
      repeat (len) @(negedge CLK);
      if (len >= LONG) begin
         check("id_settled", int'(SUBSAMPLE_ID), int'(m_id));
         check("err_settled", int'(ERR), exp_err());
      end
   endtask

   task automatic seg(input logic [9:0] v, input int len);
      drive(v);
      settle(v, len);
   endtask

   task automatic do_reset(input int hold);
      check("sb_empty_before_reset", sb_q.size(), 0);
      #2 RESET = 1'b1;
      #1;
      check("async_reset_id", int'(SUBSAMPLE_ID), int'(RID));
      check("async_reset_chg", int'(ID_CHANGED), 0);
      check("async_reset_sen", int'(SAMPLE_EN), 0);
      check("async_reset_err", int'(ERR), 0);
      repeat (hold) @(negedge CLK);
      RESET = 1'b0;
      m_id  = RID;
      m_deb = '0;
   endtask

   function automatic logic [9:0] rand_vec();
      logic [7:0] s;
      int         k;
      k = $urandom_range(0, 3);
      case (k)
         0:       s = 8'd0;
         1, 2:    s = 8'd1 << $urandom_range(0, 7);
         default: begin
            s = 8'($urandom);
            while ($countones(s) < 2) s = 8'($urandom);
         end
      endcase
      return {2'($urandom_range(0, 3)), s};
   endfunction

   // Monitor: pops an expectation on every ID_CHANGED and tracks strobe spacing at the expected rate
   bit          exp_next  = 1'b0;
   bit          have_last = 1'b0;
   int unsigned last_se   = 0;
   logic [2:0]  sb_id     = RID;

   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            have_last = 1'b0;
            exp_next  = 1'b0;
            sb_id     = RID;
         end else begin
            if (exp_next) begin
               check("sample_en_after_change", int'(SAMPLE_EN), 1);
               exp_next = 1'b0;
            end
            if (ID_CHANGED) begin
               check_range("id_changed_expected", sb_q.size(), 1, 1 << 30);
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  check("id_value", int'(SUBSAMPLE_ID), int'(e.id));
                  check_range("id_latency", int'(cyc - e.start), DB + 2, DB + 4);
                  sb_id = e.id;
               end
               exp_next  = 1'b1;
               have_last = 1'b0;
            end else if (SAMPLE_EN) begin
               if (have_last)
                  check("sample_en_gap", int'(cyc - last_se), 1 << sb_id);
               last_se   = cyc;
               have_last = 1'b1;
            end else if (have_last && int'(cyc - last_se) > (1 << sb_id)) begin
               check("sample_en_gap", int'(cyc - last_se), 1 << sb_id);
               have_last = 1'b0;
            end
         end
      end
   end

   initial begin
      logic [9:0] v;
      RESET = 1'b1;
      drive(10'h010);
      m_id  = RID;
      m_deb = '0;
      repeat (3) @(negedge CLK);
      check("reset_id", int'(SUBSAMPLE_ID), int'(RID));
      check("reset_chg", int'(ID_CHANGED), 0);
      check("reset_sen", int'(SAMPLE_EN), 0);
      check("reset_err", int'(ERR), 0);

      // Switch held one-hot through reset loads after release; long hold exercises 16-cycle strobe
      RESET = 1'b0;
      settle(10'h010, LONG + 60);

      for (int i = 0; i < 8; i++)
         seg((i % 2 == 0) ? 10'h001 : 10'h002, DB / 2);
      seg(10'h005, LONG + 2);
      seg(10'h004, LONG + 2);

      seg(10'h080, LONG + 5);
      drive(10'h040);
      repeat (DB / 2) @(negedge CLK);
      do_reset(3);
      settle(10'h040, LONG + 25);

      seg(10'h080, LONG);
      seg(10'h180, LONG);
      seg(10'h080, LONG);
      for (int i = 0; i < 8; i++) begin
         seg(10'h280, LONG);
         seg(10'h080, LONG);
      end
      seg(10'h380, LONG);
      seg(10'h080, LONG);
      seg(10'h108, LONG);
      seg(10'h008, LONG);

      for (int n = 0; n < 150; n++) begin
         do v = rand_vec(); while (((v ^ last_vec) & KEY_MASK) == 10'd0);
         if ($urandom_range(0, 9) < 4)
            seg(v, $urandom_range(2, DB - 1));
         else
            seg(v, $urandom_range(LONG, 2 * DB + 10));
      end

      repeat (DB + 8) @(negedge CLK);
      check("sb_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
